// File: rtl/ws2812_frame_ctrl.sv
// WS2812 frame sequencer: fetches GRB words from pixel RAM,
// feeds the RZ encoder one word at a time, then holds the latch gap.
module ws2812_frame_ctrl #(
  parameter int LED_NUM      = 64,
  parameter int ADDR_W       = 6,
  parameter int RESET_CYCLES = 3000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              frame_done,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_en,
  input  logic [23:0]       rd_data,
  output logic [23:0]       pix_rgb,
  output logic              tx_en,
  input  logic              tx_done
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH0,
    LOAD0,
    SEND,
    LATCH
  } state_e;

  localparam logic [ADDR_W:0] NUM  = (ADDR_W+1)'(LED_NUM);
  localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(LED_NUM - 1);
  localparam logic [15:0]     CEND = 16'(RESET_CYCLES - 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [15:0]         cnt_q, cnt_d;
  logic [23:0]         nxt_q, nxt_d;
  logic                nxt_vld_q, nxt_vld_d;
  logic                pf_pend_q, pf_pend_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic                rd_en_q, rd_en_d;
  logic [23:0]         pix_q, pix_d;
  logic                tx_en_q, tx_en_d;
  logic                done_q, done_d;
  logic [ADDR_W:0]     idx_ext;
  logic [ADDR_W:0]     idx_p2;

  assign idx_ext = {1'b0, idx_q};
  assign idx_p2  = idx_ext + (ADDR_W+1)'(2);

  // Next-state and output decode; abort overrides everything mid-frame
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    nxt_d     = nxt_q;
    nxt_vld_d = nxt_vld_q;
    rd_addr_d = rd_addr_q;
    rd_en_d   = 1'b0;
    pix_d     = pix_q;
    tx_en_d   = tx_en_q;
    done_d    = 1'b0;
    pf_pend_d = rd_en_q && (state_q == SEND);
    unique case (state_q)
      IDLE: begin
        if (start && !abort) begin
          rd_addr_d = '0;
          rd_en_d   = 1'b1;
          state_d   = FETCH0;
        end
      end
      FETCH0: begin
        state_d = LOAD0;
      end
      LOAD0: begin
        pix_d     = rd_data;
        tx_en_d   = 1'b1;
        idx_d     = '0;
        nxt_vld_d = 1'b0;
        if (NUM > (ADDR_W+1)'(1)) begin
          rd_addr_d = ADDR_W'(1);
          rd_en_d   = 1'b1;
        end
        state_d = SEND;
      end
      SEND: begin
        if (pf_pend_q) begin
          nxt_d     = rd_data;
          nxt_vld_d = 1'b1;
        end
        if (tx_done) begin
          if (idx_ext != LAST) begin
            pix_d     = nxt_q;
            idx_d     = idx_q + ADDR_W'(1);
            nxt_vld_d = 1'b0;
            if (idx_p2 < NUM) begin
              rd_addr_d = idx_p2[ADDR_W-1:0];
              rd_en_d   = 1'b1;
            end
          end else begin
            tx_en_d = 1'b0;
            cnt_d   = '0;
            state_d = LATCH;
          end
        end
      end
      LATCH: begin
        tx_en_d = 1'b0;
        cnt_d   = cnt_q + 16'd1;
        if (cnt_q == CEND) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (abort && (state_q == FETCH0 ||
                  state_q == LOAD0 ||
                  state_q == SEND)) begin
      tx_en_d   = 1'b0;
      rd_en_d   = 1'b0;
      rd_addr_d = rd_addr_q;
      nxt_vld_d = 1'b0;
      pf_pend_d = 1'b0;
      idx_d     = idx_q;
      pix_d     = pix_q;
      cnt_d     = '0;
      state_d   = LATCH;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      cnt_q     <= '0;
      nxt_q     <= '0;
      nxt_vld_q <= 1'b0;
      pf_pend_q <= 1'b0;
      rd_addr_q <= '0;
      rd_en_q   <= 1'b0;
      pix_q     <= '0;
      tx_en_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      nxt_q     <= nxt_d;
      nxt_vld_q <= nxt_vld_d;
      pf_pend_q <= pf_pend_d;
      rd_addr_q <= rd_addr_d;
      rd_en_q   <= rd_en_d;
      pix_q     <= pix_d;
      tx_en_q   <= tx_en_d;
      done_q    <= done_d;
    end
  end

  assign busy       = (state_q != IDLE);
  assign frame_done = done_q;
  assign rd_addr    = rd_addr_q;
  assign rd_en      = rd_en_q;
  assign pix_rgb    = pix_q;
  assign tx_en      = tx_en_q;

  // Encoder must never finish a non-final word before the prefetch lands
  a_nxt_ready: assert property (
    @(posedge clk) disable iff (!rst_n)
    (state_q == SEND && tx_done && !abort && idx_ext != LAST)
      |-> nxt_vld_q
  );

endmodule

// File: tb/tb_ws2812_frame_ctrl.sv
// Bench for ws2812_frame_ctrl: three instances (4/1/2 LEDs),
// RAM and encoder models, frame-level reference checks.
module tb_ws2812_frame_ctrl;

  localparam int W = 48;

  logic        clk;
  logic        rst_n;
  logic        start      [3];
  logic        abort      [3];
  logic        busy       [3];
  logic        frame_done [3];
  logic [5:0]  rd_addr    [3];
  logic        rd_en      [3];
  logic [23:0] rd_data    [3];
  logic [23:0] pix        [3];
  logic        tx_en      [3];
  logic        tx_done    [3];
  logic [7:0]  ecnt       [3];
  logic [23:0] mem        [3][64];

  int checks = 0;
  int errors = 0;

  function automatic int num_of(input int d);
    case (d)
      0: return 4;
      1: return 1;
      default: return 2;
    endcase
  endfunction

  function automatic int rcy_of(input int d);
    case (d)
      0: return 3000;
      1: return 20;
      default: return 1;
    endcase
  endfunction

  ws2812_frame_ctrl #(.LED_NUM(4), .ADDR_W(6), .RESET_CYCLES(3000)) u_d0 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .abort(abort[0]),
    .busy(busy[0]), .frame_done(frame_done[0]),
    .rd_addr(rd_addr[0]), .rd_en(rd_en[0]), .rd_data(rd_data[0]),
    .pix_rgb(pix[0]), .tx_en(tx_en[0]), .tx_done(tx_done[0])
  );

  ws2812_frame_ctrl #(.LED_NUM(1), .ADDR_W(6), .RESET_CYCLES(20)) u_d1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .abort(abort[1]),
    .busy(busy[1]), .frame_done(frame_done[1]),
    .rd_addr(rd_addr[1]), .rd_en(rd_en[1]), .rd_data(rd_data[1]),
    .pix_rgb(pix[1]), .tx_en(tx_en[1]), .tx_done(tx_done[1])
  );

  ws2812_frame_ctrl #(.LED_NUM(2), .ADDR_W(6), .RESET_CYCLES(1)) u_d2 (
    .clk(clk), .rst_n(rst_n), .start(start[2]), .abort(abort[2]),
    .busy(busy[2]), .frame_done(frame_done[2]),
    .rd_addr(rd_addr[2]), .rd_en(rd_en[2]), .rd_data(rd_data[2]),
    .pix_rgb(pix[2]), .tx_en(tx_en[2]), .tx_done(tx_done[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pixel RAM: one-cycle read latency
  always @(posedge clk) begin
    for (int d = 0; d < 3; d++)
      if (rd_en[d]) rd_data[d] <= mem[d][rd_addr[d]];
  end

  // Encoder: each word lasts W cycles, tx_done in its last cycle
  always @(posedge clk or negedge rst_n) begin
    for (int d = 0; d < 3; d++) begin
      if (!rst_n) begin
        ecnt[d]    <= '0;
        tx_done[d] <= 1'b0;
      end else if (!tx_en[d]) begin
        ecnt[d]    <= '0;
        tx_done[d] <= 1'b0;
      end else begin
        tx_done[d] <= (ecnt[d] == 8'(W - 2));
        ecnt[d]    <= (ecnt[d] == 8'(W - 1)) ? 8'd0 : ecnt[d] + 8'd1;
      end
    end
  end

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic fill(input int d);
    for (int i = 0; i < 64; i++) mem[d][i] = 24'($urandom);
  endtask

  // One frame from start to frame_done; ak>0 aborts on the ak-th tx_done
  task automatic frame(input int d, input int ak, input bit extra,
                       input bit b2b, input bit already);
    int n, words, na, cyc, hi, last_hi, fd, first_rd;
    int dones, bad_chg, bad_busy, budget;
    logic [23:0] prev_pix;
    bit prev_en, prev_done;
    logic [5:0]  addrs[$];
    logic [23:0] pixs[$];
    n = num_of(d);
    words = (ak != 0) ? ak : n;
    na = ((words < n - 1) ? words : n - 1) + 1;
    budget = n * W + rcy_of(d) + 50;
    cyc = 0; hi = 0; last_hi = 0; fd = 0; first_rd = 0;
    dones = 0; bad_chg = 0; bad_busy = 0;
    prev_pix = pix[d]; prev_en = tx_en[d]; prev_done = 1'b0;
    if (!already) start[d] = 1'b1;
    while (fd == 0 && cyc < budget) begin
      @(negedge clk);
      cyc++;
      start[d] = 1'b0;
      abort[d] = 1'b0;
      if (rd_en[d]) begin
        if (first_rd == 0) first_rd = cyc;
        addrs.push_back(rd_addr[d]);
      end
      if (tx_en[d]) begin
        hi++;
        last_hi = cyc;
      end
      if (tx_en[d] && (!prev_en || prev_done))
        pixs.push_back(pix[d]);
      else if (pix[d] !== prev_pix)
        bad_chg++;
      if (frame_done[d]) begin
        fd = cyc;
        if (busy[d]) bad_busy++;
        if (b2b) start[d] = 1'b1;
      end else if (!busy[d]) begin
        bad_busy++;
      end
      if (tx_done[d]) begin
        dones++;
        if (dones == ak) abort[d] = 1'b1;
      end
      if (extra && hi == 5 && tx_en[d]) start[d] = 1'b1;
      prev_pix = pix[d];
      prev_en = tx_en[d];
      prev_done = tx_done[d];
    end
    chk($sformatf("d%0d frame_done_seen", d), 64'(fd != 0), 64'(1));
    chk($sformatf("d%0d first_rd_cycle", d), 64'(first_rd), 64'(1));
    chk($sformatf("d%0d n_reads", d), 64'(addrs.size()), 64'(na));
    for (int i = 0; i < na && i < addrs.size(); i++)
      chk($sformatf("d%0d rd_addr[%0d]", d, i),
          64'(addrs[i]), 64'(i));
    chk($sformatf("d%0d n_words", d), 64'(pixs.size()), 64'(words));
    for (int i = 0; i < words && i < pixs.size(); i++)
      chk($sformatf("d%0d pix[%0d]", d, i),
          64'(pixs[i]), 64'(mem[d][i]));
    chk($sformatf("d%0d tx_en_cycles", d), 64'(hi), 64'(words * W));
    chk($sformatf("d%0d latch_gap", d),
        64'(fd - last_hi), 64'(rcy_of(d) + 1));
    chk($sformatf("d%0d pix_glitch", d), 64'(bad_chg), 64'(0));
    chk($sformatf("d%0d busy_shape", d), 64'(bad_busy), 64'(0));
    if (!b2b) begin
      @(negedge clk);
      chk($sformatf("d%0d done_pulse", d),
          64'({frame_done[d], busy[d]}), 64'(0));
    end
  endtask

  initial begin
    #20_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad, d, ak;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      start[i] = 1'b0;
      abort[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++)
      chk($sformatf("d%0d reset_outs", i),
          64'({busy[i], frame_done[i], rd_en[i], tx_en[i],
               rd_addr[i], pix[i]}), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // Known 4-pixel frame
    mem[0][0] = 24'hFF0000;
    mem[0][1] = 24'h00FF00;
    mem[0][2] = 24'h0000FF;
    mem[0][3] = 24'hA5A5A5;
    frame(0, 0, 1'b0, 1'b0, 1'b0);

    // Single LED, no prefetch
    mem[1][0] = 24'h123456;
    frame(1, 0, 1'b0, 1'b0, 1'b0);

    // start+abort together in IDLE is dropped
    start[0] = 1'b1;
    abort[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    abort[0] = 1'b0;
    chk("idle_start_abort", 64'({busy[0], rd_en[0]}), 64'(0));

    // Start while busy ignored, start on frame_done accepted
    fill(0);
    frame(0, 0, 1'b1, 1'b1, 1'b0);
    fill(0);
    frame(0, 0, 1'b0, 1'b0, 1'b1);

    // Abort coincident with the 2nd tx_done
    fill(0);
    frame(0, 2, 1'b0, 1'b0, 1'b0);

    // Minimal latch gap, normal and aborted
    fill(2);
    frame(2, 0, 1'b0, 1'b0, 1'b0);
    fill(2);
    frame(2, 1, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset mid-SEND
    fill(0);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (60) @(negedge clk);
    chk("pre_rst_tx_en", 64'(tx_en[0]), 64'(1));
    rst_n = 1'b0;
    #1;
    chk("rst_async_outs",
        64'({tx_en[0], busy[0], rd_en[0], pix[0]}), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (busy[0] || rd_en[0] || tx_en[0]) bad++;
    end
    chk("rst_stays_idle", 64'(bad), 64'(0));

    // Randomized frames
    for (int r = 0; r < 5; r++) begin
      d = int'($urandom_range(0, 2));
      ak = ($urandom_range(0, 1) == 0) ? 0
           : int'($urandom_range(1, num_of(d)));
      fill(d);
      frame(d, ak, 1'b0, 1'b0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
